// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative MIPS multiply/divide sequencer owning HI/LO; define MULDIV_FAST_MUL_EN for single-cycle multiply
module muldiv_seq #(
    parameter int ITER = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        issue_valid,
    input  logic [3:0]  mul_control,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        hi_wen,
    input  logic        lo_wen,
    input  logic        rd_hi_req,
    input  logic        rd_lo_req,
    input  logic        flush,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done,
    output logic        stall
);
    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;
    state_t state, state_nxt;
    logic [5:0]  cnt;
    logic [31:0] opnd, a_mag, b_mag, q_fix, r_fix;
    logic [63:0] acc, step_div, prod, mul_res;
    logic [33:0] diff;
    logic        neg_q, neg_r, sgn, is_div, accept, ge, last, fin, wr, mt;
    // acc holds {partial, multiplier} for MUL and {remainder, quotient} for DIV
    assign sgn    = mul_control[0] | mul_control[2];
    assign is_div = mul_control[2] | mul_control[3];
    assign a_mag  = sgn & src_a[31] ? -src_a : src_a;
    assign b_mag  = sgn & src_b[31] ? -src_b : src_b;
    assign accept = state == IDLE & issue_valid & |mul_control & ~flush;
    assign diff     = {1'b0, acc[63:31]} - {2'b0, opnd};
    assign ge       = ~diff[33];
    assign step_div = {ge ? diff[31:0] : acc[62:31], acc[30:0], ge};
`ifdef MULDIV_FAST_MUL_EN
    assign prod = {32'b0, opnd} * {32'b0, acc[31:0]};
    assign last = state == DIV ? cnt == 6'(ITER - 1) : 1'b1;
`else
    logic [32:0] mul_sum;
    assign mul_sum = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);
    assign prod    = {mul_sum, acc[31:1]};
    assign last    = cnt == 6'(ITER - 1);
`endif
    assign mul_res = neg_q ? -prod : prod;
    // a zero divisor leaves the all-ones quotient unsigned
    assign q_fix   = neg_q & |opnd ? -step_div[31:0] : step_div[31:0];
    assign r_fix   = neg_r ? -step_div[63:32] : step_div[63:32];
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    always_comb begin
        state_nxt = state;
        if (state == IDLE) state_nxt = accept ? (is_div ? DIV : MUL) : IDLE;
        else if (flush | last) state_nxt = IDLE;
    end
    always_comb begin
        busy  = state != IDLE;
        fin   = busy & last;
        wr    = fin & ~flush;
        mt    = state == IDLE & ~accept & ~flush;
        stall = busy & (rd_hi_req | rd_lo_req | hi_wen | lo_wen | (issue_valid & |mul_control));
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            cnt   <= '0;
            opnd  <= '0;
            acc   <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (accept) begin
            cnt   <= '0;
            opnd  <= is_div ? b_mag : a_mag;
            acc   <= {32'b0, is_div ? a_mag : b_mag};
            neg_q <= sgn & (src_a[31] ^ src_b[31]);
            neg_r <= sgn & src_a[31];
        end else if (busy) begin
            cnt <= cnt + 6'd1;
            acc <= state == MUL ? prod : step_div;
        end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            hi   <= '0;
            lo   <= '0;
            done <= 1'b0;
        end else begin
            done <= wr;
            if (wr & state == MUL) {hi, lo} <= mul_res;
            else if (wr) {hi, lo} <= {r_fix, q_fix};
            else if (mt) begin
                if (hi_wen) hi <= src_a;
                if (lo_wen) lo <= src_a;
            end
        end
endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: directed self-checking bench for muldiv_seq
module tb_muldiv_seq;
    logic        clk = 1'b0, rst = 1'b1;
    logic        issue_valid = 1'b0, hi_wen = 1'b0, lo_wen = 1'b0;
    logic        rd_hi_req = 1'b0, rd_lo_req = 1'b0, flush = 1'b0;
    logic [3:0]  mul_control = '0;
    logic [31:0] src_a = '0, src_b = '0, hi, lo;
    logic        busy, done, stall;
    int vectors = 0, errors = 0;
`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 32;
`endif
    localparam int DIV_LAT = 32;
    muldiv_seq dut (
        .clk(clk), .rst(rst), .issue_valid(issue_valid), .mul_control(mul_control),
        .src_a(src_a), .src_b(src_b), .hi_wen(hi_wen), .lo_wen(lo_wen),
        .rd_hi_req(rd_hi_req), .rd_lo_req(rd_lo_req), .flush(flush),
        .hi(hi), .lo(lo), .busy(busy), .done(done), .stall(stall)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask
    task automatic run_op(input string tag, input logic [3:0] ctl, input logic [31:0] a, input logic [31:0] b,
                          input bit hold, input int lat, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int n, idle_cnt, nostall;
        idle_cnt = 0;
        nostall  = 0;
        @(negedge clk);
        issue_valid = 1'b1; mul_control = ctl; src_a = a; src_b = b;
        @(negedge clk);
        issue_valid = 1'b0; mul_control = '0; rd_hi_req = hold;
        n = 1;
        while (!done && n < 60) begin
            if (!busy) idle_cnt++;
            if (hold && !stall) nostall++;
            @(negedge clk);
            n++;
        end
        check({tag, " latency"}, 64'(n), 64'(lat + 1));
        check({tag, " busy gaps"}, 64'(idle_cnt), 64'd0);
        check({tag, " hi/lo"}, {hi, lo}, {exp_hi, exp_lo});
        check({tag, " busy after"}, 64'(busy), 64'd0);
        if (hold) begin
            check({tag, " stall held"}, 64'(nostall), 64'd0);
            check({tag, " stall released"}, 64'(stall), 64'd0);
        end
        rd_hi_req = 1'b0;
        @(negedge clk);
        check({tag, " done single"}, 64'(done), 64'd0);
    endtask
    initial begin
        repeat (2) @(negedge clk);
        check("reset outputs", {hi, lo, 29'b0, busy, done, stall}, 64'd0);
        rst = 1'b0;
        @(negedge clk);
        hi_wen = 1'b1; src_a = 32'h1234;
        @(negedge clk);
        hi_wen = 1'b0;
        check("mthi", {hi, lo}, {32'h1234, 32'h0});
        lo_wen = 1'b1; src_a = 32'h5678;
        @(negedge clk);
        lo_wen = 1'b0;
        check("mtlo", {hi, lo}, {32'h1234, 32'h5678});
        run_op("mult -2*3", 4'b0001, 32'hFFFFFFFE, 32'd3, 1'b0, MUL_LAT, 32'hFFFFFFFF, 32'hFFFFFFFA);
        run_op("divu 100/7", 4'b1000, 32'd100, 32'd7, 1'b1, DIV_LAT, 32'd2, 32'd14);
        run_op("div -7/2", 4'b0100, 32'hFFFFFFF9, 32'd2, 1'b0, DIV_LAT, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run_op("div min/-1", 4'b0100, 32'h80000000, 32'hFFFFFFFF, 1'b0, DIV_LAT, 32'h0, 32'h80000000);
        run_op("div 5/0", 4'b0100, 32'd5, 32'd0, 1'b0, DIV_LAT, 32'd5, 32'hFFFFFFFF);
        issue_valid = 1'b1; mul_control = 4'b1000; src_a = 32'd1000; src_b = 32'd3;
        @(negedge clk);
        issue_valid = 1'b0; mul_control = '0;
        repeat (9) @(negedge clk);
        check("flush busy before", 64'(busy), 64'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush busy", 64'(busy), 64'd0);
        check("flush hi/lo", {hi, lo}, {32'd5, 32'hFFFFFFFF});
        begin
            int seen;
            seen = 0;
            repeat (30) begin
                if (done) seen++;
                @(negedge clk);
            end
            check("flush no done", 64'(seen), 64'd0);
        end
        issue_valid = 1'b1; mul_control = 4'b0001; src_a = 32'd7; src_b = 32'd9;
        @(negedge clk);
        issue_valid = 1'b0; mul_control = '0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst mid-op", {hi, lo, 29'b0, busy, done, stall}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        check("rst discards op", {hi, lo, 29'b0, busy, done, stall}, 64'd0);
        run_op("multu max*max", 4'b0010, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, MUL_LAT, 32'hFFFFFFFE, 32'h00000001);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
